// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned LAT_MIN = 1;
   localparam int unsigned LAT_MAX = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage; read data holds until the next read.
module dmem_array #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned IDX_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Storage write; contents are never cleared.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= wdata;
      end
   end

   // Read register; only loads update it, so it holds the last load result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= 32'd0;
      end else if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with a valid/ready request side and
// a one-cycle response pulse. Optional error reporting: DMEM_ERR_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        start_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        rsp_valid_o,
`ifdef DMEM_ERR_EN
   output logic        err_o,
`endif
   output logic [31:0] data_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 2);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      wdata_q;
   logic             wr_q;
   logic             bad_q;
   logic             zero_q;
   logic             zero_rsp;
   logic             err_q;
   logic [31:0]      rdata;

   logic             accept_c;
   logic             in_bad_c;
   logic             in_zero_c;
   logic             go_resp_c;
   logic             cur_bad_c;
   logic             cur_wr_c;
   logic [IDX_W-1:0] cur_idx_c;
   logic [31:0]      cur_wdata_c;
   logic             mem_en_c;

`ifdef DMEM_ERR_EN
   assign in_bad_c = (addr_i[1:0] != 2'b00) || (addr_i[31:IDX_W+2] != '0);
   assign err_o    = err_q;
`else
   logic unused_addr_c;
   assign in_bad_c      = 1'b0;
   assign unused_addr_c = ^{addr_i[1:0], addr_i[31:IDX_W+2], err_q};
`endif

   // Acceptance, and storage access on the edge that enters RESP.
   always_comb begin
      accept_c    = 1'b0;
      go_resp_c   = 1'b0;
      accept_c    = (state == IDLE) && req_valid_i && (MemRead_i || MemWrite_i);
      in_zero_c   = (MemRead_i && MemWrite_i) || in_bad_c;
      cur_idx_c   = (state == IDLE) ? addr_i[IDX_W+1:2] : idx_q;
      cur_wdata_c = (state == IDLE) ? data_i : wdata_q;
      cur_wr_c    = (state == IDLE) ? MemWrite_i : wr_q;
      cur_bad_c   = (state == IDLE) ? in_bad_c : bad_q;
      if (LATENCY == 1) begin
         go_resp_c = start_i && accept_c;
      end else begin
         go_resp_c = start_i && (state == BUSY) && (cnt == '0);
      end
      mem_en_c = go_resp_c && !cur_bad_c;
   end

   // Control FSM with registered handshake and response flags.
   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         state       <= IDLE;
         cnt         <= '0;
         idx_q       <= '0;
         wdata_q     <= 32'd0;
         wr_q        <= 1'b0;
         bad_q       <= 1'b0;
         zero_q      <= 1'b0;
         zero_rsp    <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_o <= 1'b0;
         req_ready_o <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  idx_q       <= addr_i[IDX_W+1:2];
                  wdata_q     <= data_i;
                  wr_q        <= MemWrite_i;
                  bad_q       <= in_bad_c;
                  zero_q      <= in_zero_c;
                  req_ready_o <= 1'b0;
                  if (LATENCY == 1) begin
                     state       <= RESP;
                     rsp_valid_o <= 1'b1;
                     zero_rsp    <= in_zero_c;
                     err_q       <= in_bad_c;
                  end else begin
                     state <= BUSY;
                     cnt   <= LAT_LOAD;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  zero_rsp    <= zero_q;
                  err_q       <= bad_q;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               state       <= IDLE;
               rsp_valid_o <= 1'b0;
               zero_rsp    <= 1'b0;
               err_q       <= 1'b0;
               req_ready_o <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               rsp_valid_o <= 1'b0;
               zero_rsp    <= 1'b0;
               err_q       <= 1'b0;
               req_ready_o <= 1'b1;
            end
         endcase
      end
   end

   // Forced-zero responses override the held load data only while in RESP.
   assign data_o = zero_rsp ? 32'd0 : rdata;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk  (clk_i),
      .rst_n(start_i),
      .en   (mem_en_c),
      .we   (cur_wr_c),
      .idx  (cur_idx_c),
      .wdata(cur_wdata_c),
      .rdata(rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1
// instances), checked against a word-array reference model.
module tb_dmem_responder;

   localparam int unsigned D2 = 256;
   localparam int unsigned D1 = 16;
`ifdef DMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        start2, start1, valid2, valid1, rd, wr;
   logic [31:0] addr, wdata;
   logic        ready2, ready1, rsp2, rsp1;
   logic [31:0] data2, data1;
`ifdef DMEM_ERR_EN
   logic        err2, err1;
`endif

   logic [31:0] mem2 [D2];
   logic [31:0] mem1 [D1];
   logic [31:0] last2, last1;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(D2), .LATENCY(2)) u_dut2 (
      .clk_i(clk), .start_i(start2), .req_valid_i(valid2), .req_ready_o(ready2),
      .MemRead_i(rd), .MemWrite_i(wr), .addr_i(addr), .data_i(wdata),
      .rsp_valid_o(rsp2),
`ifdef DMEM_ERR_EN
      .err_o(err2),
`endif
      .data_o(data2));

   dmem_responder #(.DEPTH_WORDS(D1), .LATENCY(1)) u_dut1 (
      .clk_i(clk), .start_i(start1), .req_valid_i(valid1), .req_ready_o(ready1),
      .MemRead_i(rd), .MemWrite_i(wr), .addr_i(addr), .data_i(wdata),
      .rsp_valid_o(rsp1),
`ifdef DMEM_ERR_EN
      .err_o(err1),
`endif
      .data_o(data1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic f_ready(input int s);
      return (s == 2) ? ready2 : ready1;
   endfunction
   function automatic logic f_rsp(input int s);
      return (s == 2) ? rsp2 : rsp1;
   endfunction
   function automatic logic [31:0] f_data(input int s);
      return (s == 2) ? data2 : data1;
   endfunction
`ifdef DMEM_ERR_EN
   function automatic logic f_err(input int s);
      return (s == 2) ? err2 : err1;
   endfunction
`endif

   task automatic set_valid(input int s, input logic v);
      if (s == 2) valid2 = v;
      else        valid1 = v;
   endtask

   // One full transaction: present, accept, wait for response, check vs model.
   task automatic xact(input int s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
      int          lat   = (s == 2) ? 2 : 1;
      int unsigned depth = (s == 2) ? D2 : D1;
      int          cyc;
      int unsigned idx;
      logic        bad_a;
      logic [31:0] lastv, expd;
      @(negedge clk);
      check("ready_idle", 32'(f_ready(s)), 32'd1);
      rd = r; wr = w; addr = a; wdata = d;
      set_valid(s, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_valid(s, 1'b0);
      rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; wdata = $urandom;
      cyc = 1;
      while (!f_rsp(s) && cyc < 20) begin
         check("ready_busy", 32'(f_ready(s)), 32'd0);
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(lat));
      if (!f_rsp(s)) return;
      bad_a = ERR_EN && ((a[1:0] != 2'b00) || (a >= 32'(4 * depth)));
      idx   = (a >> 2) % depth;
      lastv = (s == 2) ? last2 : last1;
      if (bad_a) begin
         expd = 32'd0;
      end else if (w) begin
         if (s == 2) mem2[idx] = d;
         else        mem1[idx] = d;
         expd = r ? 32'd0 : lastv;
      end else begin
         expd  = (s == 2) ? mem2[idx] : mem1[idx];
         lastv = expd;
      end
      if (s == 2) last2 = lastv;
      else        last1 = lastv;
      check("rsp_data", f_data(s), expd);
      check("ready_rsp", 32'(f_ready(s)), 32'd0);
`ifdef DMEM_ERR_EN
      check("rsp_err", 32'(f_err(s)), 32'(bad_a));
`endif
      @(negedge clk);
      check("rsp_pulse", 32'(f_rsp(s)), 32'd0);
      check("data_hold", f_data(s), lastv);
`ifdef DMEM_ERR_EN
      check("err_low", 32'(f_err(s)), 32'd0);
`endif
   endtask

   initial begin
      int          nresp;
      int          prev;
      int          s;
      int          c;
      logic [31:0] a;

      start2 = 1'b0; start1 = 1'b0; valid2 = 1'b0; valid1 = 1'b0;
      rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
      last2 = 32'd0; last1 = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_ready2", 32'(ready2), 32'd1);
      check("rst_rsp2", 32'(rsp2), 32'd0);
      check("rst_data2", data2, 32'd0);
      check("rst_ready1", 32'(ready1), 32'd1);
      check("rst_data1", data1, 32'd0);
`ifdef DMEM_ERR_EN
      check("rst_err2", 32'(err2), 32'd0);
`endif
      start2 = 1'b1; start1 = 1'b1;

      // Fill both memories so every later load has a known expected value.
      for (int i = 0; i < int'(D2); i++) xact(2, 1'b0, 1'b1, 32'(i * 4), $urandom);
      for (int i = 0; i < int'(D1); i++) xact(1, 1'b0, 1'b1, 32'(i * 4), $urandom);

      // Store then load.
      xact(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      xact(2, 1'b1, 1'b0, 32'h10, 32'd0);
      check("st_ld_deadbeef", last2, 32'hDEADBEEF);

      // Back-to-back loads with valid held high.
      @(negedge clk);
      rd = 1'b1; wr = 1'b0; addr = 32'h10; valid2 = 1'b1;
      nresp = 0; prev = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         check("b2b_ready", 32'(ready2), 32'(i % 3 == 0));
         if (rsp2) begin
            nresp++;
            check("b2b_data", data2, mem2[4]);
            if (prev >= 0) check("b2b_gap", 32'(i - prev), 32'd3);
            prev = i;
         end
      end
      valid2 = 1'b0;
      check("b2b_count", 32'(nresp), 32'd10);
      last2 = mem2[4];

      // Reset while BUSY aborts the store.
      @(negedge clk);
      rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h1; valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy_ready", 32'(ready2), 32'd0);
      valid2 = 1'b0; start2 = 1'b0;
      @(negedge clk);
      check("abort_rsp", 32'(rsp2), 32'd0);
      check("abort_ready", 32'(ready2), 32'd1);
      check("abort_data", data2, 32'd0);
      last2  = 32'd0;
      start2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort_no_rsp", 32'(rsp2), 32'd0);
      end
      xact(2, 1'b1, 1'b0, 32'h20, 32'd0);

`ifdef DMEM_ERR_EN
      xact(2, 1'b1, 1'b0, 32'h3, 32'd0);
      xact(2, 1'b0, 1'b1, 32'h400, 32'h12345678);
      xact(2, 1'b1, 1'b0, 32'h0, 32'd0);
`else
      xact(2, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
      xact(2, 1'b1, 1'b0, 32'h0, 32'd0);
      check("wrap_a5", last2, 32'hA5A5A5A5);
`endif

      // Both commands set: store with zero response data.
      xact(2, 1'b1, 1'b1, 32'h30, $urandom);
      xact(2, 1'b1, 1'b0, 32'h30, 32'd0);

      // LATENCY=1 instance and an ignored command.
      xact(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
      xact(1, 1'b1, 1'b0, 32'h8, 32'd0);
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; addr = 32'h8; valid1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("nocmd_rsp", 32'(rsp1), 32'd0);
         check("nocmd_ready", 32'(ready1), 32'd1);
      end
      valid1 = 1'b0;

      // Randomized mix on both instances.
      for (int i = 0; i < 200; i++) begin
         s = ($urandom_range(0, 1) == 0) ? 2 : 1;
         c = int'($urandom_range(1, 3));
         a = $urandom;
         if (ERR_EN && $urandom_range(0, 3) != 0)
            a = 32'(($urandom % ((s == 2) ? D2 : D1)) * 4);
         xact(s, c[0], c[1], a, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
